bus_arbiter: RTL and testbench

// Merges the CPU instruction-fetch port (imemory_*) and data port (dmemory_*) onto the single

---
 rtl/bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_bus_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: merges the instruction-fetch and data ports onto one memory request bus.
// Each port owns one holding register. Only one transaction is outstanding at a time.
// The response pulse is routed back to the port that owns the transaction.
module bus_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        reset,
    input  logic        clock,

    input  logic        imemory_valid,
    input  logic        imemory_instr,
    input  logic [31:0] imemory_addr,
    input  logic [31:0] imemory_wdata,
    input  logic [3:0]  imemory_wstrb,
    output logic [31:0] imemory_rdata,
    output logic        imemory_ready,

    input  logic        dmemory_valid,
    input  logic        dmemory_instr,
    input  logic [31:0] dmemory_addr,
    input  logic [31:0] dmemory_wdata,
    input  logic [3:0]  dmemory_wstrb,
    output logic [31:0] dmemory_rdata,
    output logic        dmemory_ready,

    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready
);

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    state_t state_q, state_d;
    req_t   i_hold_q, i_hold_d;
    req_t   d_hold_q, d_hold_d;
    req_t   mem_req_q, mem_req_d;
    logic   mem_valid_q, mem_valid_d;
    logic   pend_i_q, pend_i_d;
    logic   pend_d_q, pend_d_d;
    logic   owner_q, owner_d;
    logic   last_grant_q, last_grant_d;

    logic   response;
    logic   i_accept;
    logic   d_accept;
    logic   grant;

    // Next-state logic: capture new requests, grant one pending request from IDLE, and retire on memory_ready.
    always_comb begin
        state_d      = state_q;
        i_hold_d     = i_hold_q;
        d_hold_d     = d_hold_q;
        mem_req_d    = mem_req_q;
        mem_valid_d  = 1'b0;
        pend_i_d     = pend_i_q;
        pend_d_d     = pend_d_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        grant        = PORT_D;

        response = (state_q == BUSY) && memory_ready;

        i_accept = imemory_valid && !pend_i_q &&
                   !((state_q == BUSY) && (owner_q == PORT_I) && !memory_ready);
        d_accept = dmemory_valid && !pend_d_q &&
                   !((state_q == BUSY) && (owner_q == PORT_D) && !memory_ready);

        if (state_q == IDLE) begin
            if (pend_i_q || pend_d_q) begin
                if (pend_i_q && pend_d_q) begin
                    grant = (ROUND_ROBIN != 1'b0) ? ~last_grant_q : PORT_D;
                end else begin
                    grant = pend_d_q ? PORT_D : PORT_I;
                end
                if (grant == PORT_I) begin
                    mem_req_d = i_hold_q;
                    pend_i_d  = 1'b0;
                end else begin
                    mem_req_d = d_hold_q;
                    pend_d_d  = 1'b0;
                end
                mem_valid_d  = 1'b1;
                owner_d      = grant;
                last_grant_d = grant;
                state_d      = BUSY;
            end
        end else if (memory_ready) begin
            state_d = IDLE;
        end

        if (i_accept) begin
            pend_i_d = 1'b1;
            i_hold_d = '{instr: imemory_instr, addr: imemory_addr,
                         wdata: imemory_wdata, wstrb: imemory_wstrb};
        end
        if (d_accept) begin
            pend_d_d = 1'b1;
            d_hold_d = '{instr: dmemory_instr, addr: dmemory_addr,
                         wdata: dmemory_wdata, wstrb: dmemory_wstrb};
        end
    end

    // State registers with synchronous active-low reset; an in-flight response is dropped by returning to IDLE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            i_hold_q     <= '0;
            d_hold_q     <= '0;
            mem_req_q    <= '0;
            mem_valid_q  <= 1'b0;
            pend_i_q     <= 1'b0;
            pend_d_q     <= 1'b0;
            owner_q      <= PORT_I;
            last_grant_q <= PORT_I;
        end else begin
            state_q      <= state_d;
            i_hold_q     <= i_hold_d;
            d_hold_q     <= d_hold_d;
            mem_req_q    <= mem_req_d;
            mem_valid_q  <= mem_valid_d;
            pend_i_q     <= pend_i_d;
            pend_d_q     <= pend_d_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign memory_valid = mem_valid_q;
    assign memory_instr = mem_req_q.instr;
    assign memory_addr  = mem_req_q.addr;
    assign memory_wdata = mem_req_q.wdata;
    assign memory_wstrb = mem_req_q.wstrb;

    assign imemory_ready = response && (owner_q == PORT_I);
    assign dmemory_ready = response && (owner_q == PORT_D);
    assign imemory_rdata = imemory_ready ? memory_rdata : 32'h0;
    assign dmemory_rdata = dmemory_ready ? memory_rdata : 32'h0;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: drives a round-robin and a fixed-priority arbiter with the same stimulus.
// Both arbiters are compared against a transaction-level reference model.
module tb_bus_arbiter;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic        clock;
    logic        rst_n;
    logic        iv, dv, mready;
    req_t        ireq, dreq;
    logic [31:0] mrdata;

    logic        rr_memory_valid, rr_memory_instr, rr_imemory_ready, rr_dmemory_ready;
    logic [31:0] rr_memory_addr, rr_memory_wdata, rr_imemory_rdata, rr_dmemory_rdata;
    logic [3:0]  rr_memory_wstrb;
    logic        fp_memory_valid, fp_memory_instr, fp_imemory_ready, fp_dmemory_ready;
    logic [31:0] fp_memory_addr, fp_memory_wdata, fp_imemory_rdata, fp_dmemory_rdata;
    logic [3:0]  fp_memory_wstrb;

    int compared = 0;
    int mismatched = 0;

    bus_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
        .reset(rst_n), .clock(clock),
        .imemory_valid(iv), .imemory_instr(ireq.instr), .imemory_addr(ireq.addr),
        .imemory_wdata(ireq.wdata), .imemory_wstrb(ireq.wstrb),
        .imemory_rdata(rr_imemory_rdata), .imemory_ready(rr_imemory_ready),
        .dmemory_valid(dv), .dmemory_instr(dreq.instr), .dmemory_addr(dreq.addr),
        .dmemory_wdata(dreq.wdata), .dmemory_wstrb(dreq.wstrb),
        .dmemory_rdata(rr_dmemory_rdata), .dmemory_ready(rr_dmemory_ready),
        .memory_valid(rr_memory_valid), .memory_instr(rr_memory_instr),
        .memory_addr(rr_memory_addr), .memory_wdata(rr_memory_wdata),
        .memory_wstrb(rr_memory_wstrb), .memory_rdata(mrdata), .memory_ready(mready)
    );

    bus_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
        .reset(rst_n), .clock(clock),
        .imemory_valid(iv), .imemory_instr(ireq.instr), .imemory_addr(ireq.addr),
        .imemory_wdata(ireq.wdata), .imemory_wstrb(ireq.wstrb),
        .imemory_rdata(fp_imemory_rdata), .imemory_ready(fp_imemory_ready),
        .dmemory_valid(dv), .dmemory_instr(dreq.instr), .dmemory_addr(dreq.addr),
        .dmemory_wdata(dreq.wdata), .dmemory_wstrb(dreq.wstrb),
        .dmemory_rdata(fp_dmemory_rdata), .dmemory_ready(fp_dmemory_ready),
        .memory_valid(fp_memory_valid), .memory_instr(fp_memory_instr),
        .memory_addr(fp_memory_addr), .memory_wdata(fp_memory_wdata),
        .memory_wstrb(fp_memory_wstrb), .memory_rdata(mrdata), .memory_ready(mready)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model, one copy per arbiter (0 = round robin, 1 = fixed priority).
    // Port index 0 is the fetch port and port index 1 is the data port.
    bit   m_pend  [2][2];
    req_t m_held  [2][2];
    bit   m_busy  [2];
    int   m_owner [2];
    int   m_last  [2];
    req_t m_bus   [2];
    bit   m_bus_valid [2];

    function automatic req_t mk(input logic instr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb);
        req_t r;
        r.instr = instr;
        r.addr  = addr;
        r.wdata = wdata;
        r.wstrb = wstrb;
        return r;
    endfunction

    task automatic model_clock(input int k);
        bit   v[2];
        req_t r[2];
        bit   take[2];
        int   g;
        v[0] = iv;
        v[1] = dv;
        r[0] = ireq;
        r[1] = dreq;
        if (rst_n === 1'b0) begin
            for (int p = 0; p < 2; p++) begin
                m_pend[k][p] = 1'b0;
                m_held[k][p] = '0;
            end
            m_busy[k] = 1'b0;
            m_owner[k] = 0;
            m_last[k] = 0;
            m_bus[k] = '0;
            m_bus_valid[k] = 1'b0;
            return;
        end
        for (int p = 0; p < 2; p++) begin
            take[p] = v[p] && !m_pend[k][p] && !(m_busy[k] && m_owner[k] == p && !mready);
        end
        m_bus_valid[k] = 1'b0;
        if (!m_busy[k]) begin
            if (m_pend[k][0] || m_pend[k][1]) begin
                if (m_pend[k][0] && m_pend[k][1]) begin
                    g = (k == 0) ? 1 - m_last[k] : 1;
                end else begin
                    g = m_pend[k][1] ? 1 : 0;
                end
                m_bus[k] = m_held[k][g];
                m_bus_valid[k] = 1'b1;
                m_pend[k][g] = 1'b0;
                m_owner[k] = g;
                m_last[k] = g;
                m_busy[k] = 1'b1;
            end
        end else if (mready) begin
            m_busy[k] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            if (take[p]) begin
                m_pend[k][p] = 1'b1;
                m_held[k][p] = r[p];
            end
        end
    endtask

    task automatic cmp(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int k, input logic mv, input req_t mb,
                              input logic ir, input logic [31:0] ird,
                              input logic dr, input logic [31:0] drd);
        string n;
        bit    eir, edr;
        n = (k == 0) ? "rr" : "fp";
        eir = m_busy[k] && (mready === 1'b1) && (m_owner[k] == 0);
        edr = m_busy[k] && (mready === 1'b1) && (m_owner[k] == 1);
        cmp($sformatf("%s_memory_valid", n), 69'(mv), 69'(m_bus_valid[k]));
        cmp($sformatf("%s_memory_bus", n), 69'(mb), 69'(m_bus[k]));
        cmp($sformatf("%s_imemory_ready", n), 69'(ir), 69'(eir));
        cmp($sformatf("%s_imemory_rdata", n), 69'(ird), 69'(eir ? mrdata : 32'h0));
        cmp($sformatf("%s_dmemory_ready", n), 69'(dr), 69'(edr));
        cmp($sformatf("%s_dmemory_rdata", n), 69'(drd), 69'(edr ? mrdata : 32'h0));
    endtask

    task automatic checkOutput();
        check_inst(0, rr_memory_valid,
                   {rr_memory_instr, rr_memory_addr, rr_memory_wdata, rr_memory_wstrb},
                   rr_imemory_ready, rr_imemory_rdata, rr_dmemory_ready, rr_dmemory_rdata);
        check_inst(1, fp_memory_valid,
                   {fp_memory_instr, fp_memory_addr, fp_memory_wdata, fp_memory_wstrb},
                   fp_imemory_ready, fp_imemory_rdata, fp_dmemory_ready, fp_dmemory_rdata);
    endtask

    task automatic applyStimulus(input bit vi, input req_t ri, input bit vd, input req_t rd,
                                 input bit mr, input logic [31:0] data);
        iv = vi;
        ireq = ri;
        dv = vd;
        dreq = rd;
        mready = mr;
        mrdata = data;
    endtask

    task automatic tick();
        @(negedge clock);
        checkOutput();
        @(posedge clock);
        model_clock(0);
        model_clock(1);
        #1;
        iv = 1'b0;
        dv = 1'b0;
        mready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Directed scenarios followed by a randomized run, all checked cycle by cycle against the model.
    initial begin
        rst_n = 1'b0;
        iv = 1'b0;
        dv = 1'b0;
        mready = 1'b0;
        mrdata = 32'h0;
        ireq = '0;
        dreq = '0;
        repeat (2) @(posedge clock);
        model_clock(0);
        model_clock(1);
        #1;
        rst_n = 1'b1;

        $display("[TB] reset in the middle of a transaction");
        applyStimulus(1, mk(1, 32'h40, 32'h0, 4'h0), 0, '0, 0, 32'h0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        applyStimulus(0, '0, 0, '0, 1, 32'h12345678);
        #1;
        cmp("t1_no_ready_in_reset", 69'(rr_imemory_ready), 69'(1'b0));
        tick();
        tick();
        rst_n = 1'b1;
        cmp("t1_valid_zero", 69'(rr_memory_valid), 69'(1'b0));
        cmp("t1_addr_zero", 69'(rr_memory_addr), 69'(32'h0));
        cmp("t1_fp_instr_zero", 69'(fp_memory_instr), 69'(1'b0));

        $display("[TB] single fetch");
        applyStimulus(1, mk(1, 32'h100, 32'h0, 4'h0), 0, '0, 0, 32'h0);
        tick();
        tick();
        cmp("t2_issue_valid", 69'(rr_memory_valid), 69'(1'b1));
        cmp("t2_issue_addr", 69'(rr_memory_addr), 69'(32'h100));
        cmp("t2_issue_instr", 69'(rr_memory_instr), 69'(1'b1));
        tick();
        tick();
        applyStimulus(0, '0, 0, '0, 1, 32'hDEADBEEF);
        #1;
        cmp("t2_iready", 69'(rr_imemory_ready), 69'(1'b1));
        cmp("t2_irdata", 69'(rr_imemory_rdata), 69'(32'hDEADBEEF));
        cmp("t2_dready_idle", 69'(rr_dmemory_ready), 69'(1'b0));
        tick();

        $display("[TB] tie with round robin");
        do_reset();
        applyStimulus(1, mk(0, 32'h10, 32'h11111111, 4'hF), 1, mk(0, 32'h20, 32'h22222222, 4'hF),
                      0, 32'h0);
        tick();
        tick();
        cmp("t3_rr_first_d", 69'(rr_memory_addr), 69'(32'h20));
        cmp("t3_fp_first_d", 69'(fp_memory_addr), 69'(32'h20));
        tick();
        applyStimulus(0, '0, 0, '0, 1, $urandom);
        tick();
        tick();
        cmp("t3_rr_second_valid", 69'(rr_memory_valid), 69'(1'b1));
        cmp("t3_rr_second_i", 69'(rr_memory_addr), 69'(32'h10));
        tick();
        applyStimulus(0, '0, 0, '0, 1, $urandom);
        tick();

        $display("[TB] back-to-back ties with fixed priority");
        do_reset();
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1, mk(0, 32'h100 + 32'(r * 4), $urandom, 4'h0),
                          1, mk(0, 32'h200 + 32'(r * 4), $urandom, 4'h3),
                          r > 0, $urandom);
            tick();
            tick();
            cmp($sformatf("t4_fp_d_wins_%0d", r), 69'(fp_memory_addr), 69'(32'h200 + 32'(r * 4)));
            tick();
        end
        applyStimulus(0, '0, 0, '0, 1, $urandom);
        tick();
        tick();
        cmp("t4_fp_i_last", 69'(fp_memory_addr), 69'(32'h100));
        tick();
        applyStimulus(0, '0, 0, '0, 1, $urandom);
        tick();
        repeat (6) begin
            applyStimulus(0, '0, 0, '0, 1, $urandom);
            tick();
        end

        $display("[TB] request overlapping its own completion");
        do_reset();
        applyStimulus(1, mk(1, 32'h300, 32'h0, 4'h0), 0, '0, 0, 32'h0);
        tick();
        tick();
        tick();
        applyStimulus(1, mk(1, 32'h304, 32'h0, 4'h0), 0, '0, 1, $urandom);
        tick();
        applyStimulus(1, mk(1, 32'h308, 32'h0, 4'h0), 0, '0, 0, 32'h0);
        tick();
        cmp("t5_reissue_valid", 69'(rr_memory_valid), 69'(1'b1));
        cmp("t5_reissue_addr", 69'(rr_memory_addr), 69'(32'h304));
        tick();
        applyStimulus(0, '0, 0, '0, 1, $urandom);
        tick();
        tick();
        cmp("t5_no_second_issue", 69'(rr_memory_valid), 69'(1'b0));

        $display("[TB] stray memory_ready while idle");
        applyStimulus(0, '0, 0, '0, 1, 32'hCAFEF00D);
        #1;
        cmp("t6_rr_iready", 69'(rr_imemory_ready), 69'(1'b0));
        cmp("t6_rr_dready", 69'(rr_dmemory_ready), 69'(1'b0));
        cmp("t6_fp_dready", 69'(fp_dmemory_ready), 69'(1'b0));
        tick();
        cmp("t6_no_issue", 69'(rr_memory_valid), 69'(1'b0));

        $display("[TB] randomized traffic");
        for (int c = 0; c < 800; c++) begin
            rst_n = ($urandom_range(99) != 0);
            applyStimulus($urandom_range(2) == 0,
                          mk(1'($urandom), $urandom, $urandom, 4'($urandom)),
                          $urandom_range(2) == 0,
                          mk(1'($urandom), $urandom, $urandom, 4'($urandom)),
                          $urandom_range(2) == 0, $urandom);
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
